// File: rtl/seven_seg_mux_n_pkg.sv
// seven_seg_mux_n_pkg: shared widths, glyph table and blank glyph for the 7-segment driver
package seven_seg_mux_n_pkg;
  localparam int SEG_W = 7;
  localparam int SEG_A = 0;
  localparam int SEG_G = 6;
  localparam logic [SEG_W-1:0] SEG_BLANK = '0;
  // active-high glyphs, seg[0]=a .. seg[6]=g, indexed by nibble value
  localparam logic [SEG_W-1:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
endpackage

// File: rtl/seven_seg_mux_n_if.sv
// seven_seg_mux_n_if: valid/ready frame load port carrying per-digit segments, dp, blank and hex mode
interface seven_seg_mux_n_if
  import seven_seg_mux_n_pkg::*;
#(
  parameter int N_DIGITS = 4
);
  logic                      load_valid;
  logic                      load_ready;
  logic [SEG_W*N_DIGITS-1:0] seg_data;
  logic [N_DIGITS-1:0]       dp_data;
  logic [N_DIGITS-1:0]       blank_data;
  logic                      hex_mode;
  modport master (output load_valid, seg_data, dp_data, blank_data, hex_mode, input load_ready);
  modport slave (input load_valid, seg_data, dp_data, blank_data, hex_mode, output load_ready);
endinterface

// File: rtl/seven_seg_mux_n_hex_to_seg.sv
// seven_seg_mux_n_hex_to_seg: combinational nibble to active-high 7-segment glyph decoder
module seven_seg_mux_n_hex_to_seg
  import seven_seg_mux_n_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg
);
  assign seg = GLYPH[nibble];
endmodule

// File: rtl/seven_seg_mux_n.sv
// seven_seg_mux_n: multiplexed N-digit 7-segment scanner with frame-synchronous double buffering and PWM brightness
module seven_seg_mux_n
  import seven_seg_mux_n_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_LOG2 = 17,
  parameter int BRIGHT_W     = 3,
  parameter bit ACTIVE_LOW   = 1
)(
  input  logic                clk,
  input  logic                rst,
  seven_seg_mux_n_if.slave    ld,
  input  logic [BRIGHT_W-1:0] brightness,
  output logic                frame_start,
  output logic [SEG_W-1:0]    seg,
  output logic [N_DIGITS-1:0] an,
  output logic                dp
);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [IW-1:0] LAST = IW'(N_DIGITS - 1);
  logic [REFRESH_LOG2-1:0]   cnt;
  logic [IW-1:0]             idx;
  logic [SEG_W*N_DIGITS-1:0] stg_seg, shd_seg;
  logic [N_DIGITS-1:0]       stg_dp, stg_blank, shd_dp, shd_blank;
  logic                      stg_hex, shd_hex, pending;
  logic [BRIGHT_W-1:0]       bright;
  logic [SEG_W-1:0]          digit_seg [N_DIGITS];
  logic [SEG_W-1:0]          raw, dec, seg_on;
  logic [N_DIGITS-1:0]       an_on;
  logic                      dp_on, duty, lit, wrap;

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_unpack
    assign digit_seg[g] = shd_seg[SEG_W*g +: SEG_W];
  end

  assign raw  = digit_seg[idx];
  assign wrap = (&cnt) && (idx == LAST);
  assign duty = (&bright) || (cnt[REFRESH_LOG2-1 -: BRIGHT_W] < bright);
  assign lit  = !shd_blank[idx] && duty;
  assign ld.load_ready = !pending;

  seven_seg_mux_n_hex_to_seg u_dec (.nibble(raw[3:0]), .seg(dec));

  always_comb begin
    an_on = '0;
    for (int i = 0; i < N_DIGITS; i++) an_on[i] = lit && (idx == IW'(i));
    seg_on = lit ? (shd_hex ? dec : raw) : SEG_BLANK;
    dp_on  = lit && shd_dp[idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= '0;
      frame_start <= 1'b0;
    end else begin
      cnt         <= cnt + REFRESH_LOG2'(1);
      frame_start <= wrap;
      if (&cnt) idx <= (idx == LAST) ? '0 : idx + IW'(1);
    end
  end

  // shadow and brightness only change on the wrap edge, so a frame never tears
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_seg   <= '0;
      stg_dp    <= '0;
      stg_blank <= '0;
      stg_hex   <= 1'b0;
      shd_seg   <= '0;
      shd_dp    <= '0;
      shd_blank <= '1;
      shd_hex   <= 1'b0;
      pending   <= 1'b0;
      bright    <= '0;
    end else begin
      if (wrap) bright <= brightness;
      if (wrap && pending) begin
        shd_seg   <= stg_seg;
        shd_dp    <= stg_dp;
        shd_blank <= stg_blank;
        shd_hex   <= stg_hex;
        pending   <= 1'b0;
      end else if (ld.load_valid && !pending) begin
        stg_seg   <= ld.seg_data;
        stg_dp    <= ld.dp_data;
        stg_blank <= ld.blank_data;
        stg_hex   <= ld.hex_mode;
        pending   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= {SEG_W{ACTIVE_LOW}};
      an  <= {N_DIGITS{ACTIVE_LOW}};
      dp  <= ACTIVE_LOW;
    end else begin
      seg <= seg_on ^ {SEG_W{ACTIVE_LOW}};
      an  <= an_on ^ {N_DIGITS{ACTIVE_LOW}};
      dp  <= dp_on ^ ACTIVE_LOW;
    end
  end
endmodule
